// File: rtl/vc_test_sequencer_if.sv
// vc_test_sequencer_if
//   Handshake and result bundle between a unit-test harness and
//   vc_test_sequencer.
//   master : harness side; drives start/case_only and the per-case
//            case_done/check_valid/check_pass responses.
//   slave  : sequencer side; drives case_num/case_go, status, tallies,
//            fail_mask and the finish pulse.
interface vc_test_sequencer_if #(
    parameter int unsigned p_num_cases = 16
);
    logic                   start;
    logic [7:0]             case_only;
    logic                   case_done;
    logic                   check_valid;
    logic                   check_pass;

    logic [7:0]             case_num;
    logic                   case_go;
    logic                   busy;
    logic [15:0]            num_checks;
    logic [15:0]            num_fails;
    logic [p_num_cases-1:0] fail_mask;
    logic                   timeout_err;
    logic                   cfg_err;
    logic                   suite_done;
    logic                   finish;

    modport master (
        output start, case_only, case_done, check_valid, check_pass,
        input  case_num, case_go, busy, num_checks, num_fails, fail_mask,
               timeout_err, cfg_err, suite_done, finish
    );

    modport slave (
        input  start, case_only, case_done, check_valid, check_pass,
        output case_num, case_go, busy, num_checks, num_fails, fail_mask,
               timeout_err, cfg_err, suite_done, finish
    );
endinterface

// File: rtl/vc_test_sequencer.sv
// vc_test_sequencer
//   Steps a test suite through cases 1..p_num_cases (or one selected case),
//   pulses case_go per case, tallies check results, enforces a per-case
//   RUN timeout and pulses finish after a drain period.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : vc_test_sequencer_if.slave (control inputs, status outputs)
module vc_test_sequencer #(
    parameter int unsigned p_num_cases = 16,
    parameter int unsigned p_timeout   = 1024,
    parameter int unsigned p_settle    = 2,
    parameter int unsigned p_drain     = 4
) (
    input logic                clk,
    input logic                reset_n,
    vc_test_sequencer_if.slave bus
);
    localparam int unsigned CNT_MAX = (p_settle > p_drain) ? p_settle : p_drain;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned TW      = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_LAUNCH, S_RUN, S_NEXT, S_DRAIN, S_DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [TW-1:0]          timer;
    logic [7:0]             sel;
    logic [7:0]             case_num;
    logic                   case_go;
    logic                   busy;
    logic [15:0]            num_checks;
    logic [15:0]            num_fails;
    logic [p_num_cases-1:0] fail_mask;
    logic                   timeout_err;
    logic                   cfg_err;
    logic                   suite_done;
    logic                   finish;

    logic [p_num_cases-1:0] cur_bit;
    logic [TW-1:0]          timer_inc;
    logic                   timeout_hit;
    logic                   check_fail;
    logic                   run_timeout;
    logic [16:0]            fails_sum;
    logic [15:0]            fails_sat;

    always_comb begin
        cur_bit = '0;
        for (int unsigned i = 0; i < p_num_cases; i++) begin
            if (case_num == 8'(i + 1)) cur_bit[i] = 1'b1;
        end
        timer_inc   = timer + 1'b1;
        timeout_hit = (p_timeout != 0) && (32'(timer_inc) == p_timeout);
        check_fail  = bus.check_valid && !bus.check_pass;
        // case_done beats an expiring timer in the same cycle
        run_timeout = !bus.case_done && timeout_hit;
        // a failed check and a timeout can land together: add both, then clamp
        fails_sum   = {1'b0, num_fails} + {16'b0, check_fail} + {16'b0, run_timeout};
        fails_sat   = fails_sum[16] ? 16'hFFFF : fails_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            timer       <= '0;
            sel         <= '0;
            case_num    <= '0;
            case_go     <= 1'b0;
            busy        <= 1'b0;
            num_checks  <= '0;
            num_fails   <= '0;
            fail_mask   <= '0;
            timeout_err <= 1'b0;
            cfg_err     <= 1'b0;
            suite_done  <= 1'b0;
            finish      <= 1'b0;
        end else begin
            case_go <= 1'b0;
            finish  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        num_checks  <= '0;
                        num_fails   <= '0;
                        fail_mask   <= '0;
                        timeout_err <= 1'b0;
                        cfg_err     <= 1'b0;
                        sel         <= bus.case_only;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        suite_done  <= 1'b0;
                        state       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (32'(cnt) == p_settle) begin
                        cnt <= '0;
                        if (sel > 8'(p_num_cases)) begin
                            cfg_err  <= 1'b1;
                            case_num <= '0;
                            state    <= S_DRAIN;
                        end else begin
                            case_num <= (sel != 8'd0) ? sel : 8'd1;
                            case_go  <= 1'b1;
                            state    <= S_LAUNCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.check_valid && num_checks != 16'hFFFF) begin
                        num_checks <= num_checks + 1'b1;
                    end
                    num_fails <= fails_sat;
                    if (check_fail || run_timeout) fail_mask <= fail_mask | cur_bit;
                    if (bus.case_done) begin
                        state <= S_NEXT;
                    end else begin
                        timer <= timer_inc;
                        if (timeout_hit) begin
                            timeout_err <= 1'b1;
                            state       <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (sel != 8'd0 || case_num == 8'(p_num_cases)) begin
                        case_num <= '0;
                        cnt      <= '0;
                        state    <= S_DRAIN;
                    end else begin
                        case_num <= case_num + 8'd1;
                        case_go  <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                S_DRAIN: begin
                    if (32'(cnt) == p_drain - 1) begin
                        cnt        <= '0;
                        busy       <= 1'b0;
                        suite_done <= 1'b1;
                        finish     <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.case_num    = case_num;
    assign bus.case_go     = case_go;
    assign bus.busy        = busy;
    assign bus.num_checks  = num_checks;
    assign bus.num_fails   = num_fails;
    assign bus.fail_mask   = fail_mask;
    assign bus.timeout_err = timeout_err;
    assign bus.cfg_err     = cfg_err;
    assign bus.suite_done  = suite_done;
    assign bus.finish      = finish;
endmodule

// File: tb/tb_vc_test_sequencer.sv
// tb_vc_test_sequencer
//   Self-checking bench for vc_test_sequencer: directed suites with random
//   per-case durations and check results, predicted by a suite-level model
//   (expected launch edges, finish edge, final tallies and mask).
module tb_vc_test_sequencer;
    localparam int NC = 16;
    localparam int TO = 8;
    localparam int ST = 2;
    localparam int DR = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    vc_test_sequencer_if #(.p_num_cases(NC)) bus();

    vc_test_sequencer #(
        .p_num_cases(NC),
        .p_timeout  (TO),
        .p_settle   (ST),
        .p_drain    (DR)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        bus.start       = 1'b0;
        bus.case_only   = 8'd0;
        bus.case_done   = 1'b0;
        bus.check_valid = 1'b0;
        bus.check_pass  = 1'b0;
    endtask

    task automatic stray_inputs();
        bus.case_done   = 1'b1;
        bus.check_valid = 1'b1;
        bus.check_pass  = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] co, output int e);
        bus.start     = 1'b1;
        bus.case_only = co;
        @(negedge clk);
        e = cyc;
        bus.start     = 1'b0;
        bus.case_only = 8'($urandom_range(0, 255));
        chk("busy_at_start", bus.busy, 1);
        chk("suite_done_drop", bus.suite_done, 0);
    endtask

    task automatic wait_go(input int exp_edge, input logic [7:0] exp_num, output int g);
        int n = 0;
        while (bus.case_go !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        g = cyc;
        chk("go_seen", bus.case_go, 1);
        chk("go_edge", g, exp_edge);
        chk("go_case_num", bus.case_num, exp_num);
    endtask

    task automatic wait_finish(input int exp_edge);
        int n = 0;
        bit stray = 1'b0;
        while (bus.finish !== 1'b1 && n < 200) begin
            if (bus.case_go === 1'b1) stray = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("finish_seen", bus.finish, 1);
        chk("finish_edge", cyc, exp_edge);
        chk("no_stray_go", stray, 0);
    endtask

    task automatic run_suite(input logic [7:0] co, input int tmo_case,
                             input int poke_case, input int abort_case);
        int e, g, nxt, dur, endk, first, lastc;
        int nchk, nfail;
        bit tmo, cfg, is_tmo;
        logic [NC-1:0] mask;
        nchk = 0; nfail = 0; tmo = 1'b0; mask = '0;
        cfg = (int'(co) > NC);
        do_start(co, e);
        if (cfg) begin
            wait_finish(e + ST + 1 + DR);
        end else begin
            first = (co == 8'd0) ? 1 : int'(co);
            lastc = (co == 8'd0) ? NC : int'(co);
            nxt = e + ST + 1;
            for (int c = first; c <= lastc; c++) begin
                wait_go(nxt, 8'(c), g);
                is_tmo = (c == tmo_case);
                dur    = (c == 4) ? TO : int'($urandom_range(1, TO));
                endk   = is_tmo ? TO : dur;
                stray_inputs();
                @(negedge clk);
                for (int k = 1; k <= endk; k++) begin
                    if (c == abort_case && k == 3) begin
                        reset_n = 1'b0;
                        #1;
                        chk("abort_outputs_zero",
                            {bus.case_num, bus.case_go, bus.busy, bus.num_checks,
                             bus.num_fails, bus.fail_mask, bus.timeout_err,
                             bus.cfg_err, bus.suite_done, bus.finish}, 64'd0);
                        clear_inputs();
                        @(negedge clk);
                        reset_n = 1'b1;
                        @(negedge clk);
                        chk("abort_idle", {bus.busy, bus.case_num}, 0);
                        return;
                    end
                    bus.check_valid = 1'($urandom_range(0, 1));
                    bus.check_pass  = ($urandom_range(0, 3) != 0);
                    bus.case_done   = !is_tmo && (k == endk);
                    bus.start       = (c == poke_case && k == 1);
                    bus.case_only   = 8'd3;
                    if (bus.check_valid) begin
                        nchk++;
                        if (!bus.check_pass) begin
                            nfail++;
                            mask[c-1] = 1'b1;
                        end
                    end
                    @(negedge clk);
                end
                bus.start = 1'b0;
                if (is_tmo) begin
                    nfail++;
                    mask[c-1] = 1'b1;
                    tmo = 1'b1;
                end
                stray_inputs();
                @(negedge clk);
                clear_inputs();
                nxt = g + endk + 2;
            end
            wait_finish(nxt + DR);
        end
        chk("num_checks", bus.num_checks, nchk);
        chk("num_fails", bus.num_fails, nfail);
        chk("fail_mask", bus.fail_mask, mask);
        chk("timeout_err", bus.timeout_err, tmo);
        chk("cfg_err", bus.cfg_err, cfg);
        chk("done_status", {bus.suite_done, bus.busy, bus.case_num}, {1'b1, 1'b0, 8'd0});
        @(negedge clk);
        chk("finish_one_cycle", {bus.finish, bus.suite_done}, 2'b01);
        chk("hold_checks", bus.num_checks, nchk);
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.case_num, bus.case_go, bus.busy, bus.num_checks, bus.num_fails,
             bus.fail_mask, bus.timeout_err, bus.cfg_err, bus.suite_done, bus.finish}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {bus.busy, bus.suite_done, bus.case_go}, 0);

        run_suite(8'd0, 0, 0, 0);
        run_suite(8'd5, 0, 0, 0);
        run_suite(8'd0, 2, 4, 0);
        run_suite(8'd20, 0, 0, 0);
        run_suite(8'd16, 16, 0, 0);
        run_suite(8'd1, 0, 0, 0);
        repeat (3) run_suite(8'($urandom_range(0, NC + 2)), int'($urandom_range(1, NC)), 0, 0);
        run_suite(8'd0, 0, 0, 7);
        run_suite(8'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
